// File: rtl/gcd_pkg.sv
// Shared definitions for the time-shared GCD controller: FSM states and
// the datapath mux select encodings.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

    localparam logic [1:0] A_SEL_IN  = 2'b00;
    localparam logic [1:0] A_SEL_B   = 2'b01;
    localparam logic [1:0] A_SEL_SUB = 2'b10;
    localparam logic       B_SEL_IN  = 1'b0;
    localparam logic       B_SEL_A   = 1'b1;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr_i,
// wrapping at NREQ, so IDs outside 0..NREQ-1 are never produced.
module gcd_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/gcd_shared_ctrl.sv
// Control unit time-sharing one GCD datapath among NREQ requesters:
// round-robin grant, swap/subtract sequencing, tagged response with iteration count.
module gcd_shared_ctrl
    import gcd_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int NREQ = 4,
    parameter  int CW   = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*W-1:0] req_bits_A,
    input  logic [NREQ*W-1:0] req_bits_B,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [W-1:0]      resp_bits_data,
    output logic [IDW-1:0]    resp_bits_id,
    output logic [CW-1:0]     resp_bits_iters,
    output logic              busy,
    output logic [W-1:0]      dp_operands_bits_A,
    output logic [W-1:0]      dp_operands_bits_B,
    output logic [1:0]        dp_A_mux_sel,
    output logic              dp_B_mux_sel,
    output logic              dp_A_en,
    output logic              dp_B_en,
    input  logic              dp_B_zero,
    input  logic              dp_A_lt_B,
    input  logic [W-1:0]      dp_result_bits_data
);

    gcd_state_e      state_q;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   iters_q, iters_d;
    logic            resp_val_q;
    logic            busy_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            any_req;
    logic            step;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
    endfunction

    gcd_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i      (req_val),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (any_req)
    );

    assign dp_operands_bits_A = req_bits_A[int'(grant_id)*W +: W];
    assign dp_operands_bits_B = req_bits_B[int'(grant_id)*W +: W];

    // A CALC cycle iterates while a swap or a subtract is still needed.
    assign step     = dp_A_lt_B | ~dp_B_zero;
    assign iters_d  = sat_inc(iters_q);
    assign rr_ptr_d = ptr_next(id_q);

    assign resp_val        = resp_val_q;
    assign busy            = busy_q;
    assign resp_bits_data  = dp_result_bits_data;
    assign resp_bits_id    = id_q;
    assign resp_bits_iters = iters_q;

    // Datapath strobes must act in the same cycle as the status they depend on.
    always_comb begin
        req_rdy      = '0;
        dp_A_mux_sel = A_SEL_IN;
        dp_B_mux_sel = B_SEL_IN;
        dp_A_en      = 1'b0;
        dp_B_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    req_rdy = grant;
                    dp_A_en = 1'b1;
                    dp_B_en = 1'b1;
                end
            end
            ST_CALC: begin
                if (dp_A_lt_B) begin
                    dp_A_mux_sel = A_SEL_B;
                    dp_B_mux_sel = B_SEL_A;
                    dp_A_en      = 1'b1;
                    dp_B_en      = 1'b1;
                end else if (!dp_B_zero) begin
                    dp_A_mux_sel = A_SEL_SUB;
                    dp_A_en      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            iters_q    <= '0;
            resp_val_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        id_q    <= grant_id;
                        iters_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (step) begin
                        iters_q <= iters_d;
                    end else begin
                        resp_val_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resp_rdy) begin
                        resp_val_q <= 1'b0;
                        busy_q     <= 1'b0;
                        rr_ptr_q   <= rr_ptr_d;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    resp_val_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_shared_ctrl.md
Name: gcd_shared_ctrl

Overview:
Control unit that time-shares one gcdGCDUnitDpath instance among NREQ requesters. It picks a pending request by round-robin, loads its operands into the datapath, and sequences the swap/subtract iterations until B is zero. It then returns the result tagged with the requester ID and the iteration count. It sits between the requester ports and the datapath's control/status pins.

Parameters:
W, 32, operand/result width; must match the datapath W
NREQ, 4, number of requesters (>=2); IDW = $clog2(NREQ) is a derived localparam
CW, 16, width of the iteration counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clock clk
req_val  in  NREQ  per-requester request valid
req_rdy  out  NREQ  one-hot grant/accept; low outside IDLE
req_bits_A  in  NREQ*W  packed operand A; requester i at [i*W +: W]
req_bits_B  in  NREQ*W  packed operand B
resp_val  out  1  result valid
resp_rdy  in  1  result consumer ready
resp_bits_data  out  W  GCD result
resp_bits_id  out  IDW  index of the served requester
resp_bits_iters  out  CW  swap+subtract cycles used, saturating
busy  out  1  high in CALC or DONE
dp_operands_bits_A  out  W  granted requester's A
dp_operands_bits_B  out  W  granted requester's B
dp_A_mux_sel  out  2  to datapath A_mux_sel
dp_B_mux_sel  out  1  to datapath B_mux_sel
dp_A_en  out  1  to datapath A_en
dp_B_en  out  1  to datapath B_en
dp_B_zero  in  1  from datapath
dp_A_lt_B  in  1  from datapath
dp_result_bits_data  in  W  from datapath

Behaviour:
- Reset values: state IDLE, rr_ptr=0, id_reg=0, iters=0; req_rdy=0, resp_val=0, busy=0, dp_A_en=dp_B_en=0, mux selects 00/0. The datapath shares the same reset.
- State register: IDLE -> CALC -> DONE -> IDLE.
- Control defaults in every state: dp_A_en=dp_B_en=0, dp_A_mux_sel=00, dp_B_mux_sel=0, req_rdy=0.
- IDLE: the arbiter scans req_val starting at rr_ptr, upward with wrap, and grants the first set bit g.
  - If any request is valid (combinational, same cycle): req_rdy[g]=1; dp_operands = requester g's A and B; A_sel=00, B_sel=0, A_en=B_en=1; id_reg<=g; iters<=0; next state CALC.
  - If no request is valid: stay in IDLE.
- CALC, priority order:
  - If dp_A_lt_B: swap (A_sel=01, B_sel=1, A_en=B_en=1), iters+1.
  - Else if !dp_B_zero: subtract (A_sel=10, A_en=1, B_en=0), iters+1.
  - Else: no enables; next state DONE.
  - iters saturates at 2^CW-1; the computation continues regardless.
- DONE:
  - resp_val=1; resp_bits_data=dp_result_bits_data (stable because A_en=0); resp_bits_id=id_reg; resp_bits_iters=iters.
  - On resp_rdy: next state IDLE and rr_ptr<=(id_reg+1) mod NREQ.
  - Without resp_rdy, hold all response outputs unchanged.
- Latency: if a request is accepted in cycle T, resp_val first rises in cycle T+iters+2.
- Boundaries:
  - A=0,B=0 gives result 0, iters=0.
  - B=0 gives result A, iters=0.
  - A=0,B!=0 takes one swap: result B, iters=1.
  - Requests arriving during CALC/DONE wait; req_val may drop before a grant with no effect.
  - rr_ptr wraps from NREQ-1 to 0.
  - NREQ not a power of two: IDs >= NREQ are never produced.
- Reset mid-operation: return immediately to reset values; the in-flight result is discarded with no response.
- Undefined datapath select 11 is never driven.

Decomposition:
- Package gcd_pkg: state encoding (IDLE, CALC, DONE); select constants A_SEL_IN=2'b00, A_SEL_B=2'b01, A_SEL_SUB=2'b10, B_SEL_IN=1'b0, B_SEL_A=1'b1.
- Sub-module gcd_rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant, grant_id, any.
- Top-level integration: a wrapper instantiates gcd_shared_ctrl plus the datapath.

Test Plan:
- Single request: req0 A=27,B=15 -> resp data=3, id=0, iters=9, resp_val at accept+11.
- Edge operands, one request each: (0,0)->0/iters0; (5,0)->5/iters0; (0,7)->7/iters1; (W'hFFFFFFFF,1)->1, checked against a reference model.
- Round-robin: all four req_val held high with distinct operands -> grant order 0,1,2,3,0; each response id matches its operands' GCD.
- Backpressure: resp_rdy low 5 cycles in DONE -> resp_val, data and id stable; no req_rdy asserted; the next grant follows resp_rdy.
- Reset in CALC (req2 A=1000,B=3, reset asserted mid-iteration) -> resp_val=0 and rr_ptr=0 next cycle; a later req1 is granted first.
- Saturation with CW=4: A=100,B=1 -> iters=15, data=1.
